// File: rtl/msk_sb_layer_serial.sv
// msk_sb_layer_serial: masked AES SubBytes over NBYTES/NSBOX feed cycles with valid/ready on both sides

// gen_bp_sbox: behavioural masked S-box core with a free-running SBOX_LAT-stage pipeline and fresh output masks
module gen_bp_sbox #(
  parameter int d        = 2,
  parameter int SBOX_LAT = 4,
  parameter int RND0     = 8,
  parameter int RND1     = 8,
  parameter int RND2     = 8
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic [8*d-1:0]  sh_in,
  input  logic [RND0-1:0] rnd0,
  input  logic [RND1-1:0] rnd1,
  input  logic [RND2-1:0] rnd2,
  output logic [8*d-1:0]  sh_out
);
  localparam int MW = 8*(d-1);

  logic [7:0]     x, y;
  logic [MW-1:0]  m;
  logic [8*d-1:0] sh_d;
  logic [8*d-1:0] pipe_q [SBOX_LAT];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      p ^= b[i] ? aa : 8'h00;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // GF(2^8) inverse as a^254, then the AES affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] s;
    logic [7:0] v;
    s = a;
    v = 8'h01;
    for (int i = 1; i < 8; i++) begin
      s = gmul(s, s);
      v = gmul(v, s);
    end
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  // fold all randomness into d-1 output mask bytes; last share carries the masked result
  always_comb begin
    m = '0;
    x = '0;
    sh_d = '0;
    for (int i = 0; i < RND0; i++) m[i % MW] ^= rnd0[i];
    for (int i = 0; i < RND1; i++) m[i % MW] ^= rnd1[i];
    for (int i = 0; i < RND2; i++) m[i % MW] ^= rnd2[i];
    for (int b = 0; b < 8; b++) x[b] = ^sh_in[b*d +: d];
    y = sbox(x);
    for (int b = 0; b < 8; b++) begin
      sh_d[b*d+d-1] = y[b];
      for (int s = 0; s < d-1; s++) begin
        sh_d[b*d+s] = m[s*8+b];
        sh_d[b*d+d-1] ^= m[s*8+b];
      end
    end
  end

  // free-running latency pipeline
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < SBOX_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= sh_d;
      for (int i = 1; i < SBOX_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign sh_out = pipe_q[SBOX_LAT-1];
endmodule

module msk_sb_layer_serial #(
  parameter int d        = 2,
  parameter int NBYTES   = 16,
  parameter int NSBOX    = 4,
  parameter int SBOX_LAT = 4,
  parameter int RND0     = 8*(d-1),
  parameter int RND1     = 8,
  parameter int RND2     = 8
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [8*d*NBYTES-1:0]   sh_state_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [8*d*NBYTES-1:0]   sh_state_out,
  output logic                    rnd_req,
  input  logic [NSBOX*RND0-1:0]   rnd_bus0w,
  input  logic [NSBOX*RND1-1:0]   rnd_bus1w,
  input  logic [NSBOX*RND2-1:0]   rnd_bus2w
);
  localparam int C  = NBYTES / NSBOX;
  localparam int W  = 8*d*NSBOX;
  localparam int KW = $clog2(C) + 1;
  localparam int DW = $clog2(C + SBOX_LAT) + 1;

  if (NBYTES % NSBOX != 0) begin : g_bad
    $error("NBYTES must be a multiple of NSBOX");
  end

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [KW-1:0]           cnt_q, cnt_d;
  logic [DW-1:0]           drn_q, drn_d;
  logic [8*d*NBYTES-1:0]   st_q, st_d, out_q, out_d;
  logic                    in_ready_q, in_ready_d, out_valid_q, out_valid_d, rnd_req_q, rnd_req_d;
  logic [W-1:0]            sb_in, sb_out;
  logic                    busy, cap;
  logic [DW-1:0]           ci;

  for (genvar j = 0; j < NSBOX; j++) begin : g_sbox
    gen_bp_sbox #(.d(d), .SBOX_LAT(SBOX_LAT), .RND0(RND0), .RND1(RND1), .RND2(RND2)) u_sbox (
      .clk   (clk),
      .nrst  (nrst),
      .sh_in (sb_in[j*8*d +: 8*d]),
      .rnd0  (rnd_bus0w[j*RND0 +: RND0]),
      .rnd1  (rnd_bus1w[j*RND1 +: RND1]),
      .rnd2  (rnd_bus2w[j*RND2 +: RND2]),
      .sh_out(sb_out[j*8*d +: 8*d])
    );
  end

  // feed chunk cnt_q while in FEED, zero shares otherwise; capture chunk drn_q-SBOX_LAT as it emerges
  always_comb begin
    busy = state_q == FEED || state_q == DRAIN;
    sb_in = state_q == FEED ? st_q[cnt_q*W +: W] : '0;
    cap = busy && drn_q >= DW'(SBOX_LAT);
    ci = drn_q - DW'(SBOX_LAT);
    state_d = state_q;
    cnt_d = cnt_q;
    drn_d = busy ? drn_q + DW'(1) : drn_q;
    st_d = st_q;
    out_d = out_q;
    if (state_q == IDLE && in_valid && in_ready_q) begin
      st_d = sh_state_in;
      cnt_d = '0;
      drn_d = '0;
      state_d = FEED;
    end
    if (state_q == FEED) begin
      cnt_d = cnt_q + KW'(1);
      state_d = cnt_q == KW'(C-1) ? DRAIN : FEED;
    end
    if (cap) begin
      out_d[ci*W +: W] = sb_out;
      state_d = ci == DW'(C-1) ? DONE : state_d;
    end
    if (state_q == DONE && out_ready) state_d = IDLE;
    in_ready_d = state_d == IDLE;
    out_valid_d = state_d == DONE;
    rnd_req_d = state_d == FEED || state_d == DRAIN;
  end

  // state, counters, data registers and registered handshake outputs
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      drn_q <= '0;
      st_q <= '0;
      out_q <= '0;
      in_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
      rnd_req_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      drn_q <= drn_d;
      st_q <= st_d;
      out_q <= out_d;
      in_ready_q <= in_ready_d;
      out_valid_q <= out_valid_d;
      rnd_req_q <= rnd_req_d;
    end
  end

  assign in_ready = in_ready_q;
  assign out_valid = out_valid_q;
  assign rnd_req = rnd_req_q;
  assign sh_state_out = out_q;
endmodule

// File: tb/tb_msk_sb_layer_serial.sv
// tb_msk_sb_layer_serial: scoreboard bench over NSBOX = 4, 16, 1, 2, 8
module tb_msk_sb_layer_serial;
  localparam int D = 2;
  localparam int NB = 16;
  localparam int LAT = 4;
  localparam logic [0:255][7:0] SBT = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  typedef struct {logic [127:0] exp; int acc; int lat;} item_t;

  logic clk = 0, nrst = 0, in_valid = 0, out_ready = 1, pov = 0;
  logic [255:0] sh_in = '0;
  logic [127:0] r0 = '0, r1 = '0, r2 = '0;
  logic [4:0] ir, ov, rq;
  logic [4:0][255:0] so;
  int sel = 0, cyc = 0, errs = 0, checks = 0;
  item_t sb[$];
  item_t it;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    r0 = {$urandom, $urandom, $urandom, $urandom};
    r1 = {$urandom, $urandom, $urandom, $urandom};
    r2 = {$urandom, $urandom, $urandom, $urandom};
  end

  for (genvar g = 0; g < 5; g++) begin : g_dut
    localparam int NS = g == 0 ? 4 : g == 1 ? 16 : g == 2 ? 1 : g == 3 ? 2 : 8;
    msk_sb_layer_serial #(.d(D), .NBYTES(NB), .NSBOX(NS), .SBOX_LAT(LAT)) u_dut (
      .clk         (clk),
      .nrst        (nrst),
      .in_valid    (in_valid && sel == g),
      .in_ready    (ir[g]),
      .sh_state_in (sh_in),
      .out_valid   (ov[g]),
      .out_ready   (out_ready),
      .sh_state_out(so[g]),
      .rnd_req     (rq[g]),
      .rnd_bus0w   (r0[NS*8-1:0]),
      .rnd_bus1w   (r1[NS*8-1:0]),
      .rnd_bus2w   (r2[NS*8-1:0])
    );
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int g);
    return NB / (g == 0 ? 4 : g == 1 ? 16 : g == 2 ? 1 : g == 3 ? 2 : 8) + LAT + 1;
  endfunction

  function automatic logic [127:0] recomb(input logic [255:0] s);
    logic [127:0] r;
    for (int i = 0; i < 128; i++) r[i] = s[2*i] ^ s[2*i+1];
    return r;
  endfunction

  function automatic logic [255:0] split(input logic [127:0] pt, input logic [127:0] m);
    logic [255:0] s;
    for (int i = 0; i < 128; i++) begin
      s[2*i] = m[i];
      s[2*i+1] = pt[i] ^ m[i];
    end
    return s;
  endfunction

  function automatic logic [127:0] ref_sb(input logic [127:0] pt);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = SBT[pt[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // call at a negedge; returns at the negedge after the accept cycle
  task automatic send(input logic [127:0] pt, input logic [127:0] exp, output int acc);
    int n = 0;
    while (!ir[sel] && n < 200) begin
      @(negedge clk);
      n++;
    end
    acc = cyc;
    if (!ir[sel]) chk("in_ready_timeout", 0, 1);
    else begin
      in_valid = 1;
      sh_in = split(pt, rnd128());
      sb.push_back('{exp, cyc, lat_of(sel)});
      @(negedge clk);
      in_valid = 0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(ir[sel] && sb.size() == 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!(ir[sel] && sb.size() == 0)) chk("idle_timeout", 0, 1);
  endtask

  // scoreboard: pop and compare on each rising out_valid of the selected instance
  always @(negedge clk) begin
    if (ov[sel] && !pov) begin
      if (sb.size() == 0) chk("spurious_out_valid", 1, 0);
      else begin
        it = sb.pop_front();
        chk($sformatf("latency_ns%0d", sel), cyc - it.acc, it.lat);
        chk($sformatf("result_ns%0d", sel), recomb(so[sel]), it.exp);
      end
    end
    pov = ov[sel];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [127:0] pt;
    logic [255:0] snap;
    int acc, n;
    int a[3];
    repeat (2) @(negedge clk);
    chk("rst_in_ready", ir, 0);
    chk("rst_out_valid", ov, 0);
    chk("rst_rnd_req", rq, 0);
    chk("rst_out", so[0], 0);
    nrst = 1;
    @(negedge clk);
    chk("in_ready_after_rst", ir, 5'h1f);
    send('0, {16{8'h63}}, acc);
    for (int k = 1; k <= 9; k++) begin
      chk($sformatf("rnd_req_c%0d", k), rq[0], k < 9);
      if (k < 9) @(negedge clk);
    end
    wait_idle();
    out_ready = 0;
    pt = rnd128();
    send(pt, ref_sb(pt), acc);
    n = 0;
    while (!ov[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid", ov[0], 1);
    snap = so[0];
    for (int k = 0; k < 10; k++) begin
      in_valid = 1;
      sh_in = split(rnd128(), rnd128());
      @(negedge clk);
      chk("bp_stable", so[0], snap);
      chk("bp_in_ready", ir[0], 0);
      chk("bp_hold_valid", ov[0], 1);
    end
    in_valid = 0;
    out_ready = 1;
    @(negedge clk);
    chk("bp_release_ov", ov[0], 0);
    chk("bp_release_ir", ir[0], 1);
    pt = rnd128();
    send(pt, ref_sb(pt), acc);
    repeat (2) @(negedge clk);
    nrst = 0;
    #1;
    chk("mid_rst_ov", ov[0], 0);
    chk("mid_rst_out", so[0], 0);
    chk("mid_rst_ir", ir[0], 0);
    sb.delete();
    @(negedge clk);
    nrst = 1;
    @(negedge clk);
    send({16{8'h01}}, {16{8'h7c}}, acc);
    wait_idle();
    for (int i = 0; i < 3; i++) begin
      pt = rnd128();
      send(pt, ref_sb(pt), a[i]);
    end
    wait_idle();
    chk("b2b_gap0", a[1] - a[0], lat_of(0) + 1);
    chk("b2b_gap1", a[2] - a[1], lat_of(0) + 1);
    for (int g = 0; g < 5; g++) begin
      sel = g;
      @(negedge clk);
      if (g == 1) begin
        send(128'h00112233445566778899aabbccddeeff, 128'h638293c31bfc33f5c4eeacea4bc12816, acc);
        wait_idle();
      end
      pt = rnd128();
      for (int s = 0; s < 2; s++) begin
        send(pt, ref_sb(pt), acc);
        wait_idle();
      end
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
